// File: rtl/spu_pkg.sv
// Shared widths and bundle types for the SPU even-pipe register-fetch / forwarding stage.
package spu_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int DATA_W     = 128;
  localparam int OP_W       = 11;
  localparam int FMT_W      = 3;
  localparam int IMM_W      = 18;

  localparam logic [OP_W-1:0] OP_NOP = '0;

  // One in-flight result as presented by the downstream pipeline.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  we;
    logic                  ready;
  } fwd_entry_t;

  // Everything handed to the fixed-point execution units each cycle.
  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [FMT_W-1:0]      format;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [IMM_W-1:0]      imm;
    logic                  reg_write;
    logic [DATA_W-1:0]     ra;
    logic [DATA_W-1:0]     rb;
    logic [DATA_W-1:0]     rt_st;
  } exec_issue_t;

endpackage

// File: rtl/spu_regfile.sv
// Architectural register file: three combinational read ports, one synchronous
// write port, write-before-read bypass and a synchronous clear on reset.
module spu_regfile #(
  parameter int  NUM_REGS = 128,
  parameter int  DATA_W   = 128,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0][ADDR_W-1:0]    rd_addr,
  output logic [2:0][DATA_W-1:0]    rd_data,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage update: reset clears every entry and drops any write in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports: a write landing this cycle is returned instead of the stale entry.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 3; p++) begin
      if (wr_en && (wr_addr == rd_addr[p])) begin
        rd_data[p] = wr_data;
      end else begin
        rd_data[p] = mem[rd_addr[p]];
      end
    end
  end

endmodule

// File: rtl/spu_reg_fetch_fwd.sv
// RF/FWD stage of the SPU even pipe: reads operands, forwards in-flight results,
// stalls decode on an unresolved RAW hazard and registers the issue bundle.
module spu_reg_fetch_fwd #(
  parameter int  NUM_REGS  = 128,
  parameter int  DATA_W    = 128,
  parameter int  FWD_DEPTH = 6,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              instr_valid,
  input  logic [10:0]                       op_in,
  input  logic [2:0]                        format_in,
  input  logic [ADDR_W-1:0]                 ra_addr,
  input  logic [ADDR_W-1:0]                 rb_addr,
  input  logic [ADDR_W-1:0]                 rc_addr,
  input  logic                              ra_used,
  input  logic                              rb_used,
  input  logic                              rc_used,
  input  logic [ADDR_W-1:0]                 rt_addr_in,
  input  logic [17:0]                       imm_in,
  input  logic                              reg_write_in,
  input  logic [FWD_DEPTH-1:0][DATA_W-1:0]  fwd_data,
  input  logic [FWD_DEPTH-1:0][ADDR_W-1:0]  fwd_addr,
  input  logic [FWD_DEPTH-1:0]              fwd_we,
  input  logic [FWD_DEPTH-1:0]              fwd_ready,
  input  logic [DATA_W-1:0]                 rt_wb,
  input  logic [ADDR_W-1:0]                 rt_addr_wb,
  input  logic                              reg_write_wb,
  output logic                              stall,
  output logic [10:0]                       op,
  output logic [2:0]                        format,
  output logic [ADDR_W-1:0]                 rt_addr,
  output logic [17:0]                       imm,
  output logic                              reg_write,
  output logic [DATA_W-1:0]                 ra,
  output logic [DATA_W-1:0]                 rb,
  output logic [DATA_W-1:0]                 rt_st
);

  import spu_pkg::*;

  fwd_entry_t [FWD_DEPTH-1:0] slots;
  logic [2:0][ADDR_W-1:0]     rf_addr;
  logic [2:0][DATA_W-1:0]     rf_data;
  logic [DATA_W:0]            ra_res;
  logic [DATA_W:0]            rb_res;
  logic [DATA_W:0]            rc_res;
  logic                       hazard;
  exec_issue_t                issue_d;
  exec_issue_t                issue_q;

  // Picks the youngest writing slot that targets src; falls back to the RF/WB value.
  // Bit DATA_W of the result flags that the winning slot's data is not yet final.
  function automatic logic [DATA_W:0] resolve_src(
    input fwd_entry_t [FWD_DEPTH-1:0] s,
    input logic [ADDR_W-1:0]          src,
    input logic [DATA_W-1:0]          base
  );
    logic [DATA_W:0] res;
    res = {1'b0, base};
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (s[i].we && (s[i].addr == src)) begin
        res = {~s[i].ready, s[i].data};
      end
    end
    return res;
  endfunction

  assign rf_addr = {rc_addr, rb_addr, ra_addr};

  spu_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rf_addr),
    .rd_data (rf_data),
    .wr_en   (reg_write_wb),
    .wr_addr (rt_addr_wb),
    .wr_data (rt_wb)
  );

  // Gather the forwarding inputs into one slot bundle per pipeline position.
  always_comb begin
    slots = '0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      slots[i].data  = fwd_data[i];
      slots[i].addr  = fwd_addr[i];
      slots[i].we    = fwd_we[i];
      slots[i].ready = fwd_ready[i];
    end
  end

  // Operand resolution and hazard detection for the three sources.
  always_comb begin
    ra_res = resolve_src(slots, ra_addr, rf_data[0]);
    rb_res = resolve_src(slots, rb_addr, rf_data[1]);
    rc_res = resolve_src(slots, rc_addr, rf_data[2]);
    hazard = (ra_used && ra_res[DATA_W]) ||
             (rb_used && rb_res[DATA_W]) ||
             (rc_used && rc_res[DATA_W]);
    stall  = !reset && instr_valid && hazard;
  end

  // Assemble the bundle that is captured when the instruction issues.
  always_comb begin
    issue_d           = '0;
    issue_d.op        = op_in;
    issue_d.format    = format_in;
    issue_d.rt_addr   = rt_addr_in;
    issue_d.imm       = imm_in;
    issue_d.reg_write = reg_write_in;
    issue_d.ra        = ra_res[DATA_W-1:0];
    issue_d.rb        = rb_res[DATA_W-1:0];
    issue_d.rt_st     = rc_res[DATA_W-1:0];
  end

  // Issue register: load on a clean issue, otherwise present an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q <= '0;
    end else if (instr_valid && !stall) begin
      issue_q <= issue_d;
    end else begin
      issue_q    <= '0;
      issue_q.op <= OP_NOP;
    end
  end

  assign op        = issue_q.op;
  assign format    = issue_q.format;
  assign rt_addr   = issue_q.rt_addr;
  assign imm       = issue_q.imm;
  assign reg_write = issue_q.reg_write;
  assign ra        = issue_q.ra;
  assign rb        = issue_q.rb;
  assign rt_st     = issue_q.rt_st;

endmodule

// File: tb/tb_spu_reg_fetch_fwd.sv
// Directed, table-driven bench for the SPU register-fetch / forwarding stage.
module tb_spu_reg_fetch_fwd;

  localparam int FD = 6;

  localparam logic [127:0] P1 = {8{16'h0001}};
  localparam logic [127:0] DB = {4{32'hDEADBEEF}};
  localparam logic [127:0] VA = {16{8'hAA}};
  localparam logic [127:0] VB = {16{8'hBB}};
  localparam logic [127:0] VC = {16{8'hCC}};
  localparam logic [127:0] VD = {16{8'hDD}};
  localparam logic [127:0] VS = {1'b0, {127{1'b1}}};
  localparam logic [127:0] VX = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] VE = {8{16'hE0E0}};
  localparam logic [127:0] VZ = {16{8'h5A}};

  logic clk = 1'b0;
  logic reset;
  logic instr_valid;
  logic [10:0] op_in;
  logic [2:0] format_in;
  logic [6:0] ra_addr, rb_addr, rc_addr;
  logic ra_used, rb_used, rc_used;
  logic [6:0] rt_addr_in;
  logic [17:0] imm_in;
  logic reg_write_in;
  logic [FD-1:0][127:0] fwd_data;
  logic [FD-1:0][6:0] fwd_addr;
  logic [FD-1:0] fwd_we;
  logic [FD-1:0] fwd_ready;
  logic [127:0] rt_wb;
  logic [6:0] rt_addr_wb;
  logic reg_write_wb;
  logic stall;
  logic [10:0] op;
  logic [2:0] format;
  logic [6:0] rt_addr;
  logic [17:0] imm;
  logic reg_write;
  logic [127:0] ra, rb, rt_st;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic               valid;
    logic [10:0]        op;
    logic [2:0]         fmt;
    logic [6:0]         ra_a, rb_a, rc_a;
    logic [2:0]         used;
    logic [6:0]         rt_a;
    logic [17:0]        imm;
    logic               rw;
    logic [FD-1:0][127:0] fdata;
    logic [FD-1:0][6:0] faddr;
    logic [FD-1:0]      fwe;
    logic [FD-1:0]      frdy;
    logic [127:0]       wb_data;
    logic [6:0]         wb_addr;
    logic               wb_en;
    logic               exp_stall;
    logic [127:0]       exp_ra, exp_rb, exp_rst;
  } vec_t;

  vec_t vecs[$];

  spu_reg_fetch_fwd dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .op_in(op_in),
    .format_in(format_in), .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_used(ra_used), .rb_used(rb_used), .rc_used(rc_used), .rt_addr_in(rt_addr_in),
    .imm_in(imm_in), .reg_write_in(reg_write_in), .fwd_data(fwd_data),
    .fwd_addr(fwd_addr), .fwd_we(fwd_we), .fwd_ready(fwd_ready), .rt_wb(rt_wb),
    .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb), .stall(stall), .op(op),
    .format(format), .rt_addr(rt_addr), .imm(imm), .reg_write(reg_write),
    .ra(ra), .rb(rb), .rt_st(rt_st)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic rst);
    reset        = rst;
    instr_valid  = v.valid;
    op_in        = v.op;
    format_in    = v.fmt;
    ra_addr      = v.ra_a;
    rb_addr      = v.rb_a;
    rc_addr      = v.rc_a;
    ra_used      = v.used[0];
    rb_used      = v.used[1];
    rc_used      = v.used[2];
    rt_addr_in   = v.rt_a;
    imm_in       = v.imm;
    reg_write_in = v.rw;
    fwd_data     = v.fdata;
    fwd_addr     = v.faddr;
    fwd_we       = v.fwe;
    fwd_ready    = v.frdy;
    rt_wb        = v.wb_data;
    rt_addr_wb   = v.wb_addr;
    reg_write_wb = v.wb_en;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compares every registered output after the edge that consumed vector v.
  task automatic checkIssue(input string tag, input vec_t v);
    logic issued;
    issued = v.valid && !v.exp_stall;
    checkOutput({tag, ".op"},        128'(op),        issued ? 128'(v.op)   : 128'd0);
    checkOutput({tag, ".format"},    128'(format),    issued ? 128'(v.fmt)  : 128'd0);
    checkOutput({tag, ".rt_addr"},   128'(rt_addr),   issued ? 128'(v.rt_a) : 128'd0);
    checkOutput({tag, ".imm"},       128'(imm),       issued ? 128'(v.imm)  : 128'd0);
    checkOutput({tag, ".reg_write"}, 128'(reg_write), issued ? 128'(v.rw)   : 128'd0);
    checkOutput({tag, ".ra"},        ra,              issued ? v.exp_ra  : 128'd0);
    checkOutput({tag, ".rb"},        rb,              issued ? v.exp_rb  : 128'd0);
    checkOutput({tag, ".rt_st"},     rt_st,           issued ? v.exp_rst : 128'd0);
  endtask

  task automatic runVector(input string tag, input vec_t v, input logic rst);
    @(negedge clk);
    applyStimulus(v, rst);
    #1;
    checkOutput({tag, ".stall"}, 128'(stall), 128'(v.exp_stall));
    @(posedge clk);
    #1;
    checkIssue(tag, v);
  endtask

  task automatic buildVectors();
    vec_t v;
    // 0: write $r3 through WB, no instruction
    v = blank(); v.wb_en = 1; v.wb_addr = 3; v.wb_data = P1; vecs.push_back(v);
    // 1: read $r3 from the array
    v = blank(); v.valid = 1; v.op = 11'h123; v.fmt = 1; v.rt_a = 10; v.imm = 18'h01234; v.rw = 1;
    v.ra_a = 3; v.used = 3'b001; v.exp_ra = P1; vecs.push_back(v);
    // 2: same-cycle WB bypass on rb, extreme field values
    v = blank(); v.valid = 1; v.op = 11'h7FF; v.fmt = 7; v.rt_a = 127; v.imm = 18'h3FFFF; v.rw = 1;
    v.ra_a = 3; v.rb_a = 5; v.used = 3'b011; v.wb_en = 1; v.wb_addr = 5; v.wb_data = DB;
    v.exp_ra = P1; v.exp_rb = DB; vecs.push_back(v);
    // 3: RF[7] = C
    v = blank(); v.wb_en = 1; v.wb_addr = 7; v.wb_data = VC; vecs.push_back(v);
    // 4: slot0 and slot3 both hit $r7, youngest wins
    v = blank(); v.valid = 1; v.op = 11'h005; v.fmt = 2; v.rt_a = 8; v.rw = 1;
    v.ra_a = 7; v.rb_a = 7; v.rc_a = 7; v.used = 3'b011;
    v.fdata[0] = VA; v.faddr[0] = 7; v.fwe[0] = 1; v.frdy[0] = 1;
    v.fdata[3] = VB; v.faddr[3] = 7; v.fwe[3] = 1; v.frdy[3] = 1;
    v.exp_ra = VA; v.exp_rb = VA; v.exp_rst = VA; vecs.push_back(v);
    // 5: slot0 no longer writes, slot3 wins
    v.fwe[0] = 0; v.exp_ra = VB; v.exp_rb = VB; v.exp_rst = VB; vecs.push_back(v);
    // 6: RAW on a not-ready slot1
    v = blank(); v.valid = 1; v.op = 11'h0A0; v.fmt = 3; v.rt_a = 11; v.rw = 1; v.imm = 18'h00042;
    v.ra_a = 9; v.used = 3'b001;
    v.fdata[1] = VD; v.faddr[1] = 9; v.fwe[1] = 1; v.frdy[1] = 0;
    v.exp_stall = 1; vecs.push_back(v);
    // 7: older ready slot4 does not hide the younger pending slot1
    v.fdata[4] = VC; v.faddr[4] = 9; v.fwe[4] = 1; v.frdy[4] = 1; vecs.push_back(v);
    // 8: slot1 becomes ready
    v.fdata[1] = VS; v.frdy[1] = 1; v.exp_stall = 0; v.exp_ra = VS; vecs.push_back(v);
    // 9: slot1 pending again but ra unused -> no stall, data still forwarded
    v.fdata[1] = VD; v.frdy[1] = 0; v.used = 3'b000; v.exp_ra = VD; vecs.push_back(v);
    // 10: non-writing pending slot is ignored
    v = blank(); v.valid = 1; v.op = 11'h011; v.rt_a = 1; v.rb_a = 5; v.used = 3'b010;
    v.fdata[2] = VA; v.faddr[2] = 5; v.fwe[2] = 0; v.frdy[2] = 0;
    v.exp_rb = DB; vecs.push_back(v);
    // 11: RF[20] = X
    v = blank(); v.wb_en = 1; v.wb_addr = 20; v.wb_data = VX; vecs.push_back(v);
    // 12: immediate-format pass-through with store data from rc
    v = blank(); v.valid = 1; v.fmt = 4; v.op = 11'b00000011101; v.imm = 18'b0011111111;
    v.rt_a = 2; v.rc_a = 20; v.used = 3'b100; v.exp_rst = VX; vecs.push_back(v);
    // 13: pending slot on rc stalls; WB to the same reg still commits
    v = blank(); v.valid = 1; v.op = 11'h033; v.rc_a = 20; v.used = 3'b100;
    v.fdata[2] = VA; v.faddr[2] = 20; v.fwe[2] = 1; v.frdy[2] = 0;
    v.wb_en = 1; v.wb_addr = 20; v.wb_data = P1; v.exp_stall = 1; vecs.push_back(v);
    // 14: the write made during the stall is visible
    v = blank(); v.valid = 1; v.op = 11'h034; v.rc_a = 20; v.used = 3'b100; v.exp_rst = P1; vecs.push_back(v);
    // 15: top register, bypassed on write
    v = blank(); v.valid = 1; v.op = 11'h035; v.ra_a = 127; v.used = 3'b001;
    v.wb_en = 1; v.wb_addr = 127; v.wb_data = VE; v.exp_ra = VE; vecs.push_back(v);
    // 16: $r0 is an ordinary writable register
    v = blank(); v.wb_en = 1; v.wb_addr = 0; v.wb_data = VZ; vecs.push_back(v);
    // 17: read $r0, $r127, $r3 from the array
    v = blank(); v.valid = 1; v.op = 11'h036; v.ra_a = 0; v.rb_a = 127; v.rc_a = 3; v.used = 3'b111;
    v.exp_ra = VZ; v.exp_rb = VE; v.exp_rst = P1; vecs.push_back(v);
    // 18: oldest slot beats a same-cycle WB to $r3
    v = blank(); v.valid = 1; v.op = 11'h037; v.ra_a = 3; v.used = 3'b001;
    v.fdata[5] = VD; v.faddr[5] = 3; v.fwe[5] = 1; v.frdy[5] = 1;
    v.wb_en = 1; v.wb_addr = 3; v.wb_data = VC;
    v.exp_ra = VD; v.exp_rb = VZ; v.exp_rst = VZ; vecs.push_back(v);
    // 19: the WB value landed in $r3
    v = blank(); v.valid = 1; v.op = 11'h038; v.ra_a = 3; v.used = 3'b001;
    v.exp_ra = VC; v.exp_rb = VZ; v.exp_rst = VZ; vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    buildVectors();

    // Reset with a valid instruction that would otherwise stall.
    v = blank(); v.valid = 1; v.op = 11'h077; v.ra_a = 4; v.used = 3'b001;
    v.faddr[0] = 4; v.fwe[0] = 1; v.frdy[0] = 0;
    applyStimulus(v, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.stall", 128'(stall), 128'd0);
    v.valid = 0; v.exp_stall = 0;
    checkIssue("reset", v);

    for (int i = 0; i < vecs.size(); i++) begin
      runVector($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // Mid-stream reset: instruction discarded, WB dropped, RF cleared.
    v = blank(); v.valid = 1; v.op = 11'h055; v.rw = 1; v.rt_a = 6; v.ra_a = 3; v.used = 3'b001;
    v.faddr[0] = 3; v.fwe[0] = 1; v.frdy[0] = 0;
    v.wb_en = 1; v.wb_addr = 30; v.wb_data = VX;
    @(negedge clk);
    applyStimulus(v, 1'b1);
    #1;
    checkOutput("midrst.stall", 128'(stall), 128'd0);
    @(posedge clk);
    #1;
    v.valid = 0;
    checkIssue("midrst", v);

    v = blank(); v.valid = 1; v.op = 11'h066; v.rw = 1; v.rt_a = 9;
    v.ra_a = 30; v.rb_a = 3; v.rc_a = 0; v.used = 3'b111;
    runVector("postrst", v, 1'b0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
